alu_serial: RTL and testbench

//  Multi-cycle, digit-serial ALU for the HC4e datapath family.
//  - Processes WIDTH-bit operands one DIGIT-bit slice per clock, LSB slice first.
//  - The carry ripples through an internal carry register between slices.
//  - Lets wide operations reuse one narrow adder, so area trades against latency.
//  - Sits between the register file and write-back; a valid/ready handshake on the

---
 rtl/alu_serial.sv | 181 ++++++++++++++++++
 tb/tb_alu_serial.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial
// Description : Digit-serial ALU. Operands are processed one DIGIT-bit slice
//               per clock, LSB slice first, with the carry rippling through a
//               carry register between slices. Valid/ready on the operand
//               side, one-cycle result strobe on the output side.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       sel_in,
  input  logic             carry_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             zero_out,
  output logic             err_out,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;        // operand A, doubles as the result accumulator
  logic [WIDTH-1:0]  b_q, b_d;
  logic [2:0]        sel_q, sel_d;
  logic              carry_q, carry_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              cout_q, cout_d;
  logic              zero_q, zero_d;
  logic              err_q, err_d;

  // Slice datapath
  logic [DIGIT-1:0]  a_sl, b_sl, b_eff, slice_res;
  logic [DIGIT:0]    sum;
  logic              is_arith, is_undef, slice_carry;
  logic [WIDTH-1:0]  a_shift, b_shift;

  assign a_sl = a_q[DIGIT-1:0];
  assign b_sl = b_q[DIGIT-1:0];

  // Compute the current slice result and the carry into the next slice.
  always_comb begin
    is_arith    = (sel_q == OP_ADD) || (sel_q == OP_SUB);
    is_undef    = (sel_q[2:1] == 2'b00);
    b_eff       = (sel_q == OP_SUB) ? ~b_sl : b_sl;
    sum         = {1'b0, a_sl} + {1'b0, b_eff} + {{DIGIT{1'b0}}, carry_q};
    slice_carry = is_arith ? sum[DIGIT] : 1'b0;
    slice_res   = '0;
    case (sel_q)
      OP_ADD,
      OP_SUB:  slice_res = sum[DIGIT-1:0];
      OP_XOR:  slice_res = a_sl ^ b_sl;
      OP_AND:  slice_res = a_sl & b_sl;
      OP_OR:   slice_res = a_sl | b_sl;
      OP_PASS: slice_res = a_sl;
      default: slice_res = '0;
    endcase
  end

  // Result slices enter at the top of A while consumed operand slices leave
  // at the bottom, so after N slices A holds the complete result.
  generate
    if (N == 1) begin : g_single
      assign a_shift = slice_res;
      assign b_shift = b_q;
    end else begin : g_multi
      assign a_shift = {slice_res, a_q[WIDTH-1:DIGIT]};
      assign b_shift = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
    end
  endgenerate

  // Next-state and register-update logic for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          sel_d   = sel_in;
          carry_d = carry_in;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_shift;
        b_d     = b_shift;
        carry_d = slice_carry;
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = ST_DONE;
          out_d   = a_shift;
          cout_d  = slice_carry;
          zero_d  = (a_shift == '0);
          err_d   = is_undef;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out       = out_q;
  assign carry_out = cout_q;
  assign zero_out  = zero_q;
  assign err_out   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_serial
// Description : Self-checking bench for alu_serial. Three instances share the
//               operand bus (DIGIT = 4, 16, 1) and are checked against a
//               whole-word arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  in_valid;
  logic [15:0] in_a, in_b;
  logic [2:0]  sel_in;
  logic        carry_in;
  logic [2:0]  in_ready, out_valid, carry_out, zero_out, err_out, busy;
  logic [15:0] res [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_serial #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a), .in_b(in_b), .sel_in(sel_in), .carry_in(carry_in),
    .out_valid(out_valid[0]), .out(res[0]), .carry_out(carry_out[0]),
    .zero_out(zero_out[0]), .err_out(err_out[0]), .busy(busy[0]));

  alu_serial #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a), .in_b(in_b), .sel_in(sel_in), .carry_in(carry_in),
    .out_valid(out_valid[1]), .out(res[1]), .carry_out(carry_out[1]),
    .zero_out(zero_out[1]), .err_out(err_out[1]), .busy(busy[1]));

  alu_serial #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_a(in_a), .in_b(in_b), .sel_in(sel_in), .carry_in(carry_in),
    .out_valid(out_valid[2]), .out(res[2]), .carry_out(carry_out[2]),
    .zero_out(zero_out[2]), .err_out(err_out[2]), .busy(busy[2]));

  // Slice count of each instance
  function automatic int n_of(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  // Whole-word reference: returns {err, carry_out, zero, out}
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] sel, input logic cin);
    logic [16:0] s;
    logic [15:0] nb;
    logic [15:0] r;
    logic        c;
    logic        e;
    nb = ~b;
    c  = 1'b0;
    e  = 1'b0;
    case (sel)
      3'b011: begin s = {1'b0, a} + {1'b0, b}  + {16'd0, cin}; r = s[15:0]; c = s[16]; end
      3'b010: begin s = {1'b0, a} + {1'b0, nb} + {16'd0, cin}; r = s[15:0]; c = s[16]; end
      3'b100: r = a ^ b;
      3'b101: r = a & b;
      3'b110: r = a | b;
      3'b111: r = a;
      default: begin r = 16'h0000; e = 1'b1; end
    endcase
    return {e, c, (r == 16'h0000), r};
  endfunction

  // One operation issued to all three instances; checks result, latency,
  // strobe width, and return to IDLE.
  task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] sel, input logic cin);
    logic [18:0] exp;
    logic [18:0] got;
    int lat [3];
    int nv [3];
    int guard;
    exp   = model(a, b, sel, cin);
    guard = 0;
    while (in_ready !== 3'b111 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (in_ready !== 3'b111) begin
      errors++;
      $display("FAIL %s idle_wait: in_ready=%b required=111", name, in_ready);
    end
    in_a = a; in_b = b; sel_in = sel; carry_in = cin; in_valid = 3'b111;
    @(posedge clk); #1;
    // Scramble inputs after accept; results must come from latched values.
    in_valid = 3'b000;
    in_a = 16'($urandom); in_b = 16'($urandom);
    sel_in = 3'($urandom); carry_in = 1'($urandom);
    checks++;
    if (busy !== 3'b111 || in_ready !== 3'b000) begin
      errors++;
      $display("FAIL %s accept: busy=%b in_ready=%b required busy=111 in_ready=000",
               name, busy, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      lat[i] = 0;
      nv[i]  = 0;
    end
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (out_valid[i] === 1'b1) begin
          nv[i]++;
          if (lat[i] == 0) lat[i] = cyc;
          got = {err_out[i], carry_out[i], zero_out[i], res[i]};
          checks++;
          if (got !== exp) begin
            errors++;
            $display("FAIL %s result[N=%0d]: got err=%b cout=%b zero=%b out=%h required err=%b cout=%b zero=%b out=%h",
                     name, n_of(i), got[18], got[17], got[16], got[15:0],
                     exp[18], exp[17], exp[16], exp[15:0]);
          end
        end
        if (cyc == n_of(i) + 1) begin
          checks++;
          if (in_ready[i] !== 1'b1 || busy[i] !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_again[N=%0d]: in_ready=%b busy=%b required 1 0",
                     name, n_of(i), in_ready[i], busy[i]);
          end
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (lat[i] != n_of(i) || nv[i] != 1) begin
        errors++;
        $display("FAIL %s latency[N=%0d]: latency=%0d strobes=%0d required latency=%0d strobes=1",
                 name, n_of(i), lat[i], nv[i], n_of(i));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 3'b000; in_a = '0; in_b = '0; sel_in = '0; carry_in = 1'b0;
    #12;
    checks++;
    if (in_ready !== 3'b111 || out_valid !== 3'b000 || busy !== 3'b000 ||
        carry_out !== 3'b000 || zero_out !== 3'b000 || err_out !== 3'b000 ||
        res[0] !== 16'h0 || res[1] !== 16'h0 || res[2] !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b cout=%b zero=%b err=%b out=%h/%h/%h required ready=111 rest 0",
               in_ready, out_valid, busy, carry_out, zero_out, err_out, res[0], res[1], res[2]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_add_carry();
    do_op("add_wrap", 16'hFFFF, 16'h0001, 3'b011, 1'b0);
    do_op("add_cin",  16'h00FF, 16'h0F00, 3'b011, 1'b1);
  endtask

  task automatic test_sub();
    do_op("sub_borrow",    16'h1234, 16'h1235, 3'b010, 1'b1);
    do_op("sub_noborrow",  16'h1235, 16'h1234, 3'b010, 1'b1);
    do_op("sub_borrow_in", 16'h0000, 16'h0000, 3'b010, 1'b0);
  endtask

  task automatic test_logic();
    do_op("xor",  16'hA5A5, 16'hFFFF, 3'b100, 1'b1);
    do_op("pass", 16'h8001, 16'h1234, 3'b111, 1'b1);
    do_op("and",  16'hF0F0, 16'h3C3C, 3'b101, 1'b1);
    do_op("or",   16'h0F00, 16'h00F0, 3'b110, 1'b0);
  endtask

  task automatic test_err();
    do_op("undef000",  16'h1234, 16'h5678, 3'b000, 1'b1);
    do_op("after_err", 16'h0003, 16'h0004, 3'b011, 1'b0);
    do_op("undef001",  16'hFFFF, 16'hFFFF, 3'b001, 1'b1);
  endtask

  // Asynchronous reset two edges after accept, then a clean operation.
  task automatic test_reset_mid_run();
    do_op("pre_reset", 16'h1111, 16'h2222, 3'b011, 1'b0);
    in_a = 16'h5555; in_b = 16'h1111; sel_in = 3'b011; carry_in = 1'b1; in_valid = 3'b111;
    @(posedge clk); #1;
    in_valid = 3'b000;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 3'b111 || out_valid !== 3'b000 || busy !== 3'b000 ||
        carry_out !== 3'b000 || zero_out !== 3'b000 || err_out !== 3'b000 ||
        res[0] !== 16'h0 || res[1] !== 16'h0 || res[2] !== 16'h0) begin
      errors++;
      $display("FAIL mid_run_reset: in_ready=%b out_valid=%b busy=%b cout=%b zero=%b err=%b out=%h/%h/%h required ready=111 rest 0",
               in_ready, out_valid, busy, carry_out, zero_out, err_out, res[0], res[1], res[2]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 3'b000 || busy !== 3'b000 || res[0] !== 16'h0) begin
      errors++;
      $display("FAIL post_reset_idle: out_valid=%b busy=%b out=%h required 000 000 0000",
               out_valid, busy, res[0]);
    end
    do_op("after_reset", 16'h0F0F, 16'h00F1, 3'b011, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      do_op("random", 16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom));
    end
  endtask

  // in_valid held high with operands changing every cycle: each instance
  // must accept exactly every N+2 cycles and use the accepted operands.
  task automatic test_back_to_back();
    logic [18:0] expq [3][24];
    int          acc_cyc [3][24];
    int          wr [3];
    int          rd [3];
    logic [18:0] got;
    int          bad;
    for (int i = 0; i < 3; i++) begin
      wr[i] = 0;
      rd[i] = 0;
    end
    in_a = 16'($urandom); in_b = 16'($urandom);
    sel_in = 3'($urandom); carry_in = 1'($urandom);
    for (int cyc = 0; cyc < 80; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        in_valid[i] = (cyc < 55) && (wr[i] < 24);
        if (in_valid[i] && in_ready[i] === 1'b1) begin
          expq[i][wr[i]]    = model(in_a, in_b, sel_in, carry_in);
          acc_cyc[i][wr[i]] = cyc;
          wr[i]++;
        end
      end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (out_valid[i] === 1'b1) begin
          got = {err_out[i], carry_out[i], zero_out[i], res[i]};
          checks++;
          if (rd[i] >= wr[i]) begin
            errors++;
            $display("FAIL b2b_extra[N=%0d]: unexpected strobe out=%h", n_of(i), res[i]);
          end else begin
            if (got !== expq[i][rd[i]]) begin
              errors++;
              $display("FAIL b2b_result[N=%0d] op %0d: got %h required %h",
                       n_of(i), rd[i], got, expq[i][rd[i]]);
            end
            rd[i]++;
          end
        end
      end
      in_a = 16'($urandom); in_b = 16'($urandom);
      sel_in = 3'($urandom); carry_in = 1'($urandom);
    end
    in_valid = 3'b000;
    for (int i = 0; i < 3; i++) begin
      bad = 0;
      for (int k = 1; k < wr[i]; k++) begin
        if (acc_cyc[i][k] - acc_cyc[i][k-1] != n_of(i) + 2) bad++;
      end
      checks++;
      if (bad != 0 || wr[i] < 3 || rd[i] != wr[i]) begin
        errors++;
        $display("FAIL b2b_spacing[N=%0d]: accepts=%0d completions=%0d bad_gaps=%0d required equal counts, >=3 accepts, gaps of %0d",
                 n_of(i), wr[i], rd[i], bad, n_of(i) + 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub();
    test_logic();
    test_err();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
